cassette_stream: RTL and testbench
==================================

// Module: cassette_stream
// PURPOSE
// Parametrised tape-playback engine for the MC-10 cassette input: streams a tape image
// byte-by-byte from SDRAM over a rd/ack handshake and FSK-encodes it onto a 1-bit line.
// Single-byte prefetch gives gapless output; supports level play/pause, rewind, a
// byte-count end and an optional end marker. Status outputs drive the OSD/LED.
// PARAMETERS
// AW       25          SDRAM byte-address width
// BASE     0           SDRAM address of tape byte 0 (AW bits)
// HALF0    1500        clk cycles per half-period of a '0' bit (bit = 2*HALF0)
// HALF1    750         clk cycles per half-period of a '1' bit (bit = 2*HALF1)
// MARK_EN  1           1 = stop after the 3-byte end marker MARK is emitted
// MARK     24'h553CFF  end marker, oldest byte in bits [23:16]
// PORTS
// clk         in   1   system clock
// reset       in   1   synchronous, active-high
// play        in   1   level: 1 = run, 0 = pause
// rewind      in   1   one-cycle pulse: return to tape start
// tape_len    in   AW  image length in bytes, sampled on each start from IDLE
// sdram_addr  out  AW  read address, valid while sdram_rd = 1
// sdram_rd    out  1   read request, held until sdram_ack
// sdram_ack   in   1   one-cycle strobe; sdram_data is valid in the same cycle
// sdram_data  in   8   read data
// data        out  1   FSK tape signal
// playing     out  1   1 while a bit is being emitted
// at_end      out  1   1 in state END
// position    out  AW  count of fully emitted bytes
// BEHAVIOUR
// - Reset: state IDLE; data=0, sdram_rd=0, sdram_addr=BASE, playing=0, at_end=0,
//   position=0; buffers empty; marker shift register cleared. Reset overrides all.
// - States: IDLE, RUN, PAUSE, END.
//   IDLE->RUN when play=1: latch tape_len, fetch offset=0. tape_len==0 -> END instead.
//   RUN->PAUSE when play=0, taken at the next bit boundary; the current bit completes.
//   PAUSE->RUN when play=1; emission resumes with the next bit, no byte skipped.
//   RUN->END after the last bit of the byte that completes the tape (see End).
//   Any state -> IDLE on rewind: position=0, fetch offset=0, buffers emptied,
//   marker register cleared, sdram_rd dropped. Rewind wins over play in the same cycle.
//   Re-start from IDLE happens on the next cycle if play is still 1.
// - Fetch: in RUN or PAUSE, with the prefetch buffer empty, fetch offset < tape_len and
//   no marker fetched, assert sdram_rd with sdram_addr = BASE + fetch offset (AW-bit
//   wrap). On sdram_ack: buffer <= sdram_data, offset+1, sdram_rd <= 0 next cycle.
//   sdram_ack while sdram_rd = 0 is ignored. Fetch latency is unbounded.
// - Emission: a byte moves from buffer to the shifter when the shifter is idle,
//   LSB first. Each bit: data=1 for HALFx cycles, then data=0 for HALFx cycles.
//   Back-to-back bytes have no idle cycles when the buffer is full at the boundary.
//   Underrun: data=0 and playing=0 until the buffer fills; no partial bits.
// - Marker (MARK_EN=1): the last 3 fetched bytes are compared to MARK on each ack.
//   A match stops further fetches.
// - End: after the final bit of byte tape_len-1, or after the marker's last byte.
//   data=0, at_end=1, no requests; leave END only by rewind or reset.
// - position increments on each completed byte and saturates at tape_len.
// - Reset mid-read: request dropped; a late ack is ignored.
// TESTING
// 1 tape_len=2, bytes 0x01,0x80, ack 3 cycles after rd -> bit 0: 2*HALF1 cycles
//   (HALF1 high, HALF1 low); bits 1-7: 2*HALF0 cycles each; then byte 0x80;
//   at_end=1, position=2, exactly 2 reads.
// 2 Gapless: ack after 1 cycle -> the byte-0 to byte-1 boundary has zero extra cycles
//   between the last low half and the next high half.
// 3 Bytes 0x55,0x3C,0xFF,0xAA with tape_len=4, MARK_EN=1 -> stops after 0xFF;
//   0xAA never fetched; position=3. With MARK_EN=0 -> all 4 bytes emitted.
// 4 play=0 mid-bit -> the bit finishes, data=0, PAUSE; play=1 after 10k cycles
//   -> the next bit continues; the byte sequence equals an uninterrupted run.
// 5 Rewind while sdram_rd=1 (ack arrives 1 cycle later), play held 1 -> the late
//   ack is ignored; position=0; the next read has sdram_addr=BASE.
// 6 tape_len=0 with play=1 -> END within 2 cycles, no sdram_rd. reset mid-bit -> all
//   outputs at reset values on the next cycle.

Source files
------------

// File: rtl/cassette_stream.sv
// Tape-playback engine: prefetches tape bytes from SDRAM one at a time and
// FSK-encodes them LSB first onto a single line (HALFx high, then HALFx low per bit).
module cassette_stream #(
  parameter int          AW      = 25,
  parameter logic [AW-1:0] BASE  = '0,
  parameter int          HALF0   = 1500,
  parameter int          HALF1   = 750,
  parameter bit          MARK_EN = 1'b1,
  parameter logic [23:0] MARK    = 24'h553CFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          play,
  input  logic          rewind,
  input  logic [AW-1:0] tape_len,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ack,
  input  logic [7:0]    sdram_data,
  output logic          data,
  output logic          playing,
  output logic          at_end,
  output logic [AW-1:0] position,
  output logic [1:0]    state_dbg
);

  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_END} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   len, fetch_off;
  logic            buf_full;
  logic [7:0]      buf_data, sh_data;
  logic            sh_active, low_phase;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   cnt, half_last;
  logic [15:0]     mark_sr;
  logic            mark_hit;
  logic [23:0]     mark_next;
  logic            bit_done, byte_done, boundary, tape_done, load, fetch_req, ack_ok;

  // Handshake: sdram_rd rises with a stable sdram_addr and stays high until a
  // cycle with sdram_ack=1; that cycle carries the data. Acks with sdram_rd=0 are dropped.
  assign ack_ok    = sdram_rd && sdram_ack;
  assign mark_next = {mark_sr, sdram_data};

  assign half_last = sh_data[0] ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
  assign bit_done  = (state == S_RUN) && sh_active && low_phase && (cnt == half_last);
  assign byte_done = bit_done && (bit_idx == 3'd7);
  assign boundary  = !sh_active || bit_done;
  // Nothing left to emit once the shifter byte is out: buffer empty and no more fetches.
  assign tape_done = !buf_full && !sdram_rd && (!(fetch_off < len) || mark_hit);
  assign load      = (state == S_RUN) && play && buf_full && (!sh_active || byte_done);
  assign fetch_req = ((state == S_RUN) || (state == S_PAUSE)) && !buf_full && !sdram_rd &&
                     (fetch_off < len) && !mark_hit;

  always_comb begin
    state_nx = state;
    if (rewind) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (play) state_nx = (tape_len == '0) ? S_END : S_RUN;
        S_RUN: begin
          if (byte_done && tape_done) state_nx = S_END;
          else if (!play && boundary) state_nx = S_PAUSE;
        end
        S_PAUSE: if (play) state_nx = S_RUN;
        S_END:   state_nx = S_END;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state      <= S_IDLE;
      len        <= '0;
      fetch_off  <= '0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      sh_data    <= '0;
      sh_active  <= 1'b0;
      low_phase  <= 1'b0;
      bit_idx    <= '0;
      cnt        <= '0;
      mark_sr    <= '0;
      mark_hit   <= 1'b0;
      sdram_rd   <= 1'b0;
      sdram_addr <= BASE;
      position   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && play) begin
        len       <= tape_len;
        fetch_off <= '0;
      end

      if (fetch_req) begin
        sdram_rd   <= 1'b1;
        sdram_addr <= BASE + fetch_off;
      end else if (ack_ok) begin
        sdram_rd  <= 1'b0;
        buf_data  <= sdram_data;
        buf_full  <= 1'b1;
        fetch_off <= fetch_off + 1'b1;
        mark_sr   <= mark_next[15:0];
        mark_hit  <= MARK_EN && (mark_next == MARK);
      end

      // A waiting byte is loaded straight into the last-bit slot, so back-to-back bytes have no gap.
      if (load) begin
        sh_data   <= buf_data;
        sh_active <= 1'b1;
        bit_idx   <= '0;
        cnt       <= '0;
        low_phase <= 1'b0;
        buf_full  <= 1'b0;
      end else if (state == S_RUN && sh_active) begin
        if (bit_done) begin
          sh_data   <= {1'b0, sh_data[7:1]};
          bit_idx   <= bit_idx + 1'b1;
          cnt       <= '0;
          low_phase <= 1'b0;
          if (bit_idx == 3'd7) sh_active <= 1'b0;
        end else if (cnt == half_last) begin
          cnt       <= '0;
          low_phase <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (byte_done && (position < len)) position <= position + 1'b1;
    end
  end

  assign data      = (state == S_RUN) && sh_active && !low_phase;
  assign playing   = (state == S_RUN) && sh_active;
  assign at_end    = (state == S_END);
  assign state_dbg = state;

endmodule

// File: tb/tb_cassette_stream.sv
// Bench for cassette_stream: SDRAM responders with programmable ack delay, a line
// decoder that rebuilds bytes from pulse widths, and a byte-level tape model.
module tb_cassette_stream;

  localparam int          AW     = 25;
  localparam logic [AW-1:0] BASE = 25'h1FFFFFE;
  localparam int          HALF0  = 6;
  localparam int          HALF1  = 3;
  localparam logic [23:0] MARK_V = 24'h553CFF;

  logic          clk, reset, play, rewind;
  logic [AW-1:0] tape_len;
  logic [AW-1:0] addr_a, pos_a, addr_b, pos_b;
  logic          rd_a, ack_a, line_a, playing_a, at_end_a;
  logic          rd_b, ack_b, line_b, playing_b, at_end_b;
  logic [7:0]    sd_a, sd_b;
  logic [1:0]    st_a, st_b;

  logic [7:0] mem [0:15];
  int ack_dly;
  int n_checks = 0;
  int n_fail = 0;

  cassette_stream #(.AW(AW), .BASE(BASE), .HALF0(HALF0), .HALF1(HALF1),
                    .MARK_EN(1'b1), .MARK(MARK_V)) dut (
    .clk(clk), .reset(reset), .play(play), .rewind(rewind), .tape_len(tape_len),
    .sdram_addr(addr_a), .sdram_rd(rd_a), .sdram_ack(ack_a), .sdram_data(sd_a),
    .data(line_a), .playing(playing_a), .at_end(at_end_a), .position(pos_a),
    .state_dbg(st_a));

  cassette_stream #(.AW(AW), .BASE(BASE), .HALF0(HALF0), .HALF1(HALF1),
                    .MARK_EN(1'b0), .MARK(MARK_V)) dut_nm (
    .clk(clk), .reset(reset), .play(play), .rewind(rewind), .tape_len(tape_len),
    .sdram_addr(addr_b), .sdram_rd(rd_b), .sdram_ack(ack_b), .sdram_data(sd_b),
    .data(line_b), .playing(playing_b), .at_end(at_end_b), .position(pos_b),
    .state_dbg(st_b));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SDRAM responders ----------------
  int busy_a = 0, wait_a = 0, reads_a = 0;
  logic [AW-1:0] req_a = '0, first_a = '0;
  always @(negedge clk) begin
    ack_a = 1'b0;
    if (st_a == 2'd0) reads_a = 0;
    if (busy_a != 0) begin
      if (wait_a == 0) begin
        ack_a  = 1'b1;
        sd_a   = mem[4'(req_a - BASE)];
        busy_a = 0;
      end else wait_a--;
    end else if (rd_a) begin
      req_a = addr_a;
      if (reads_a == 0) first_a = addr_a;
      reads_a++;
      busy_a = 1;
      wait_a = ack_dly - 1;
    end
  end

  int busy_b = 0, wait_b = 0, reads_b = 0;
  logic [AW-1:0] req_b = '0;
  always @(negedge clk) begin
    ack_b = 1'b0;
    if (st_b == 2'd0) reads_b = 0;
    if (busy_b != 0) begin
      if (wait_b == 0) begin
        ack_b  = 1'b1;
        sd_b   = mem[4'(req_b - BASE)];
        busy_b = 0;
      end else wait_b--;
    end else if (rd_b) begin
      req_b = addr_b;
      reads_b++;
      busy_b = 1;
      wait_b = ack_dly - 1;
    end
  end

  // ---------------- line decoder (scoreboard input) ----------------
  logic [7:0] got_q [$];
  int lo_q [$];
  logic prev_a = 1'b0;
  logic [7:0] acc_a = '0;
  int hi_a = 0, lo_a = 0, nb_a = 0, bad_a = 0;
  bit started_a = 1'b0;
  always @(negedge clk) begin
    if (st_a == 2'd0) begin
      got_q.delete();
      lo_q.delete();
      hi_a = 0; lo_a = 0; nb_a = 0; bad_a = 0; started_a = 1'b0; prev_a = 1'b0;
    end else if (line_a) begin
      if (!prev_a && started_a) lo_q.push_back(lo_a);
      hi_a   = prev_a ? hi_a + 1 : 1;
      prev_a = 1'b1;
    end else begin
      if (prev_a) begin
        if (hi_a == HALF1) acc_a = {1'b1, acc_a[7:1]};
        else begin
          if (hi_a != HALF0) bad_a++;
          acc_a = {1'b0, acc_a[7:1]};
        end
        nb_a++;
        if (nb_a == 8) begin
          got_q.push_back(acc_a);
          nb_a = 0;
        end
        lo_a = 1;
        started_a = 1'b1;
      end else lo_a++;
      prev_a = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Bytes the tape delivers: stop at tape_len or right after a complete marker.
  function automatic int model_len(int len, bit men);
    int n = 0;
    for (int i = 0; i < len; i++) begin
      n = i + 1;
      if (men && i >= 2 && {mem[i-2], mem[i-1], mem[i]} == MARK_V) break;
    end
    return n;
  endfunction

  function automatic int stream_errs(int n);
    int e = (got_q.size() == n) ? 0 : 1;
    for (int k = 0; k < n && k < got_q.size(); k++)
      if (got_q[k] !== mem[k]) e++;
    return e + bad_a;
  endfunction

  // Every low half except the final one must be exactly the bit's half period.
  function automatic int low_errs(int n);
    int e = (lo_q.size() == 8 * n - 1) ? 0 : 1;
    for (int k = 0; k < lo_q.size(); k++) begin
      logic [7:0] b = mem[k / 8];
      if (lo_q[k] != (b[k % 8] ? HALF1 : HALF0)) e++;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tape(int len);
    @(negedge clk);
    rewind = 1'b1;
    play   = 1'b0;
    @(negedge clk);
    rewind   = 1'b0;
    tape_len = AW'(len);
    play     = 1'b1;
  endtask

  task automatic wait_both(int budget);
    int i = 0;
    while (!(at_end_a && at_end_b) && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    n_checks++;
    if ({line_a, rd_a, playing_a, at_end_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: data/rd/playing/at_end=%b required 0000",
               {line_a, rd_a, playing_a, at_end_a});
    end
    n_checks++;
    if (addr_a !== BASE || pos_a !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_pos: addr=%h pos=%0d required addr=%h pos=0", addr_a, pos_a, BASE);
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_bit_timing();
    int n;
    fill_random();
    mem[0] = 8'h01;
    mem[1] = 8'h80;
    ack_dly = 3;
    start_tape(2);
    wait_both(3000);
    n = model_len(2, 1'b1);
    n_checks++;
    if (at_end_a !== 1'b1) begin
      n_fail++; $display("FAIL t1_end: at_end=%b required 1", at_end_a);
    end
    n_checks++;
    if (stream_errs(n) !== 0) begin
      n_fail++; $display("FAIL t1_stream: %0d byte/width errors required 0", stream_errs(n));
    end
    n_checks++;
    if (low_errs(n) !== 0) begin
      n_fail++; $display("FAIL t1_lows: %0d low-half errors required 0", low_errs(n));
    end
    n_checks++;
    if (pos_a !== AW'(n) || reads_a !== n) begin
      n_fail++; $display("FAIL t1_pos_reads: pos=%0d reads=%0d required %0d/%0d", pos_a, reads_a, n, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    fill_random();
    mem[0] = 8'hA5;
    ack_dly = 1;
    start_tape(3);
    wait_both(3000);
    n = model_len(3, 1'b1);
    n_checks++;
    if (stream_errs(n) !== 0) begin
      n_fail++; $display("FAIL t2_stream: %0d errors required 0", stream_errs(n));
    end
    n_checks++;
    if (lo_q.size() < 8 || lo_q[7] !== (mem[0][7] ? HALF1 : HALF0)) begin
      n_fail++;
      $display("FAIL t2_boundary: byte0 last low=%0d required %0d",
               (lo_q.size() < 8) ? -1 : lo_q[7], mem[0][7] ? HALF1 : HALF0);
    end
    n_checks++;
    if (low_errs(n) !== 0) begin
      n_fail++; $display("FAIL t2_lows: %0d low-half errors required 0", low_errs(n));
    end
  endtask

  task automatic test_marker();
    int n;
    fill_random();
    mem[0] = 8'h55; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'hAA;
    ack_dly = 2;
    start_tape(4);
    wait_both(3000);
    n = model_len(4, 1'b1);
    n_checks++;
    if (at_end_a !== 1'b1 || stream_errs(n) !== 0) begin
      n_fail++; $display("FAIL t3_stream: at_end=%b errors=%0d required 1/0", at_end_a, stream_errs(n));
    end
    n_checks++;
    if (pos_a !== AW'(n) || reads_a !== n) begin
      n_fail++; $display("FAIL t3_mark_stop: pos=%0d reads=%0d required %0d/%0d", pos_a, reads_a, n, n);
    end
    n_checks++;
    if (at_end_b !== 1'b1 || pos_b !== AW'(model_len(4, 1'b0)) || reads_b !== model_len(4, 1'b0)) begin
      n_fail++;
      $display("FAIL t3_no_mark: at_end=%b pos=%0d reads=%0d required 1/%0d/%0d",
               at_end_b, pos_b, reads_b, model_len(4, 1'b0), model_len(4, 1'b0));
    end
  endtask

  task automatic test_pause();
    int n, i, highs;
    fill_random();
    mem[0] = 8'h6B;
    ack_dly = 2;
    start_tape(4);
    i = 0;
    while (!playing_a && i < 200) begin @(negedge clk); i++; end
    cyc(2);
    play = 1'b0;
    i = 0;
    while (playing_a && i < 2 * HALF0 + 4) begin @(negedge clk); i++; end
    n_checks++;
    if (playing_a !== 1'b0 || line_a !== 1'b0 || st_a !== 2'd2) begin
      n_fail++;
      $display("FAIL t4_paused: playing=%b data=%b state=%0d required 0/0/2", playing_a, line_a, st_a);
    end
    n_checks++;
    if (nb_a !== 1 || bad_a !== 0) begin
      n_fail++; $display("FAIL t4_bit_finish: bits=%0d bad=%0d required 1/0", nb_a, bad_a);
    end
    highs = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (line_a) highs++;
    end
    n_checks++;
    if (highs !== 0 || pos_a !== '0) begin
      n_fail++; $display("FAIL t4_silent: high samples=%0d pos=%0d required 0/0", highs, pos_a);
    end
    play = 1'b1;
    wait_both(3000);
    n = model_len(4, 1'b1);
    n_checks++;
    if (at_end_a !== 1'b1 || stream_errs(n) !== 0 || pos_a !== AW'(n)) begin
      n_fail++;
      $display("FAIL t4_resume: at_end=%b errors=%0d pos=%0d required 1/0/%0d", at_end_a, stream_errs(n), pos_a, n);
    end
  endtask

  task automatic test_rewind();
    int n, i;
    fill_random();
    ack_dly = 1;
    start_tape(5);
    i = 0;
    while (!(pos_a >= 1 && rd_a) && i < 1000) begin @(negedge clk); i++; end
    n_checks++;
    if (rd_a !== 1'b1) begin
      n_fail++; $display("FAIL t5_setup: rd=%b required 1", rd_a);
    end
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    n_checks++;
    if (pos_a !== '0 || rd_a !== 1'b0 || st_a !== 2'd0) begin
      n_fail++; $display("FAIL t5_rewound: pos=%0d rd=%b state=%0d required 0/0/0", pos_a, rd_a, st_a);
    end
    wait_both(4000);
    n = model_len(5, 1'b1);
    n_checks++;
    if (first_a !== BASE) begin
      n_fail++; $display("FAIL t5_first_addr: addr=%h required %h", first_a, BASE);
    end
    n_checks++;
    if (stream_errs(n) !== 0 || pos_a !== AW'(n) || reads_a !== n) begin
      n_fail++;
      $display("FAIL t5_replay: errors=%0d pos=%0d reads=%0d required 0/%0d/%0d", stream_errs(n), pos_a, reads_a, n, n);
    end
  endtask

  task automatic test_zero_len_and_reset();
    int rd_seen, i;
    start_tape(0);
    rd_seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rd_a || rd_b) rd_seen++;
    end
    n_checks++;
    if (at_end_a !== 1'b1 || rd_seen !== 0) begin
      n_fail++; $display("FAIL t6_zero_len: at_end=%b rd cycles=%0d required 1/0", at_end_a, rd_seen);
    end
    fill_random();
    ack_dly = 4;
    start_tape(6);
    i = 0;
    while (!playing_a && i < 200) begin @(negedge clk); i++; end
    cyc(3);
    reset = 1'b1;
    play  = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({line_a, rd_a, playing_a, at_end_a} !== 4'b0000 || addr_a !== BASE ||
        pos_a !== '0 || st_a !== 2'd0) begin
      n_fail++;
      $display("FAIL t6_reset_mid: flags=%b addr=%h pos=%0d state=%0d required 0000/%h/0/0",
               {line_a, rd_a, playing_a, at_end_a}, addr_a, pos_a, st_a, BASE);
    end
    reset = 1'b0;
    cyc(10);
  endtask

  task automatic test_random();
    int len, n;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      len = $urandom_range(1, 8);
      ack_dly = $urandom_range(1, 60);
      start_tape(len);
      wait_both(3000);
      n = model_len(len, 1'b1);
      n_checks++;
      if (at_end_a !== 1'b1 || stream_errs(n) !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_stream: at_end=%b errors=%0d required 1/0 (len=%0d dly=%0d)",
                 it, at_end_a, stream_errs(n), len, ack_dly);
      end
      n_checks++;
      if (pos_a !== AW'(n) || reads_a !== n || pos_b !== AW'(model_len(len, 1'b0))) begin
        n_fail++;
        $display("FAIL rnd%0d_counts: pos=%0d reads=%0d pos_nm=%0d required %0d/%0d/%0d",
                 it, pos_a, reads_a, pos_b, n, n, model_len(len, 1'b0));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    play     = 1'b0;
    rewind   = 1'b0;
    tape_len = '0;
    ack_dly  = 1;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    test_reset();
    test_bit_timing();
    test_back_to_back();
    test_marker();
    test_pause();
    test_rewind();
    test_zero_len_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
